// File: rtl/nukv_fifo_pkt.sv
// nukv_fifo_pkt: single-clock AXI-Stream FIFO with tlast transport, occupancy
// count, almost-full/almost-empty flags and optional store-and-forward packet
// mode. Output path is RAM -> registered read (rd_q) -> FWFT output register
// (out_q), so every DEPTH entry is usable and throughput is one word per cycle.
module nukv_fifo_pkt #(
    parameter int DATA_SIZE    = 16,
    parameter int ADDR_BITS    = 5,
    parameter int AFULL_MARGIN = 8,
    parameter int AEMPTY_LEVEL = 2,
    parameter int PACKET_MODE  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_SIZE-1:0] s_axis_tdata,
    input  logic                 s_axis_tlast,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic                 s_axis_talmostfull,
    output logic [DATA_SIZE-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_talmostempty,
    output logic [ADDR_BITS:0]   count,
    output logic [ADDR_BITS:0]   pkt_count
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CW    = ADDR_BITS + 1;
    localparam logic [CW-1:0] FULL_LVL   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_LVL  = CW'(DEPTH - AFULL_MARGIN);
    localparam logic [CW-1:0] AEMPTY_LVL = CW'(AEMPTY_LEVEL);

    // tlast is carried in the MSB of each entry
    logic [DATA_SIZE:0]   mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
    logic [DATA_SIZE:0]   rd_q, out_q;
    logic                 rd_vld, out_vld;

    logic          wr_en, pop, out_load, fetch, ram_has, head_ok;
    logic [CW-1:0] staged;

    // Words already pulled out of the RAM into the two output stages
    assign staged  = CW'(rd_vld) + CW'(out_vld);
    assign ram_has = count > staged;

    // Packet mode holds the head until a whole packet is stored; a full FIFO
    // releases it anyway so an over-long packet cannot deadlock.
    assign head_ok = (PACKET_MODE == 0) || (pkt_count != '0) || (count == FULL_LVL);

    assign s_axis_tready       = ~rst & (count < FULL_LVL);
    assign m_axis_tvalid       = ~rst & out_vld & head_ok;
    assign m_axis_tdata        = rst ? '0 : out_q[DATA_SIZE-1:0];
    assign m_axis_tlast        = ~rst & out_q[DATA_SIZE];
    assign s_axis_talmostfull  = ~rst & (count >= AFULL_LVL);
    assign m_axis_talmostempty = rst | (count <= AEMPTY_LVL);

    assign wr_en    = s_axis_tvalid & s_axis_tready;
    assign pop      = m_axis_tvalid & m_axis_tready;
    // Output register takes rd_q when empty or being popped this cycle
    assign out_load = rd_vld & (~out_vld | pop);
    // Prefetch from RAM whenever the read stage is free or drains this cycle
    assign fetch    = ram_has & (~rd_vld | out_load);

    // RAM write port (no reset: contents are don't-care until written)
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end

    // Registered RAM read feeding the prefetch stage
    always_ff @(posedge clk) begin
        if (fetch) rd_q <= mem[rd_ptr];
    end

    // Pointers, stage valids, output register and occupancy counters
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_vld    <= 1'b0;
            out_vld   <= 1'b0;
            out_q     <= '0;
            count     <= '0;
            pkt_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (fetch) rd_ptr <= rd_ptr + 1'b1;

            if (fetch)         rd_vld <= 1'b1;
            else if (out_load) rd_vld <= 1'b0;

            if (out_load) begin
                out_vld <= 1'b1;
                out_q   <= rd_q;
            end else if (pop) begin
                out_vld <= 1'b0;
            end

            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case ({wr_en & s_axis_tlast, pop & m_axis_tlast})
                2'b10:   pkt_count <= pkt_count + 1'b1;
                2'b01:   pkt_count <= pkt_count - 1'b1;
                default: pkt_count <= pkt_count;
            endcase
        end
    end
endmodule

// File: tb/tb_nukv_fifo_pkt.sv
// Bench for nukv_fifo_pkt: a cut-through and a packet-mode instance share the
// stimulus; a queue model of the stored words supplies expected data, count,
// pkt_count, ready and flags. pm selects which instance is observed.
module tb_nukv_fifo_pkt;
    localparam int DW = 16;
    localparam int AB = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0] s_tdata = '0;
    logic s_tlast = 1'b0, s_tvalid = 1'b0, m_tready = 1'b0;
    logic pm = 1'b0;

    logic [DW-1:0] a_tdata, b_tdata, o_tdata;
    logic a_tready, b_tready, o_tready, a_tlast, b_tlast, o_tlast;
    logic a_tvalid, b_tvalid, o_tvalid, a_afull, b_afull, o_afull;
    logic a_aempty, b_aempty, o_aempty;
    logic [AB:0] a_count, b_count, o_count, a_pkt, b_pkt, o_pkt;

    nukv_fifo_pkt #(.DATA_SIZE(DW), .ADDR_BITS(AB), .AFULL_MARGIN(8), .AEMPTY_LEVEL(2),
                    .PACKET_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(a_tready), .s_axis_talmostfull(a_afull),
        .m_axis_tdata(a_tdata), .m_axis_tlast(a_tlast), .m_axis_tvalid(a_tvalid),
        .m_axis_tready(m_tready), .m_axis_talmostempty(a_aempty), .count(a_count),
        .pkt_count(a_pkt));

    nukv_fifo_pkt #(.DATA_SIZE(DW), .ADDR_BITS(AB), .AFULL_MARGIN(8), .AEMPTY_LEVEL(2),
                    .PACKET_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(b_tready), .s_axis_talmostfull(b_afull),
        .m_axis_tdata(b_tdata), .m_axis_tlast(b_tlast), .m_axis_tvalid(b_tvalid),
        .m_axis_tready(m_tready), .m_axis_talmostempty(b_aempty), .count(b_count),
        .pkt_count(b_pkt));

    assign o_tready = pm ? b_tready : a_tready;
    assign o_tdata  = pm ? b_tdata  : a_tdata;
    assign o_tlast  = pm ? b_tlast  : a_tlast;
    assign o_tvalid = pm ? b_tvalid : a_tvalid;
    assign o_afull  = pm ? b_afull  : a_afull;
    assign o_aempty = pm ? b_aempty : a_aempty;
    assign o_count  = pm ? b_count  : a_count;
    assign o_pkt    = pm ? b_pkt    : a_pkt;

    int n_err = 0;
    int n_chk = 0;
    logic [DW:0] mq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int n_last();
        int n = 0;
        foreach (mq[i]) if (mq[i][DW]) n++;
        return n;
    endfunction

    // One clock: apply handshakes to the model, step the edge, compare state
    task automatic cyc();
        bit w, r, hold;
        w = 0; r = 0; hold = 0;
        if (!rst) begin
            w    = s_tvalid & o_tready;
            r    = o_tvalid & m_tready;
            hold = o_tvalid & ~m_tready;
            if (r) begin
                if (mq.size() == 0) chk("pop_empty", 1, 0);
                else begin
                    chk("data", {o_tlast, o_tdata}, mq[0]);
                    void'(mq.pop_front());
                end
            end
            if (w) mq.push_back({s_tlast, s_tdata});
        end
        @(posedge clk); #1;
        if (rst) mq.delete();
        chk("count", o_count, mq.size());
        chk("pkt_count", o_pkt, n_last());
        chk("tready", o_tready, !rst && mq.size() < DEPTH);
        chk("afull", o_afull, !rst && mq.size() >= DEPTH - 8);
        chk("aempty", o_aempty, rst || mq.size() <= 2);
        if (hold) begin
            chk("hold_vld", o_tvalid, 1);
            chk("hold_data", {o_tlast, o_tdata}, mq[0]);
        end
    endtask

    task automatic drain(input string tag);
        s_tvalid = 0;
        m_tready = 1;
        for (int k = 0; k < 500 && mq.size() != 0; k++) cyc();
        chk(tag, mq.size(), 0);
    endtask

    initial begin
        int sent, i;
        bit acc;

        // Reset, with a write attempt that must be ignored
        rst = 1; s_tvalid = 1; s_tdata = 16'hdead;
        cyc(); cyc();
        chk("rst_vld", o_tvalid, 0);
        chk("rst_data", o_tdata, 0);
        chk("rst_rdy", o_tready, 0);
        rst = 0; s_tvalid = 0;
        cyc();
        chk("post_rst_rdy", o_tready, 1);

        // Fill to full with output stalled, then drain in order
        m_tready = 0;
        for (int k = 0; k < DEPTH; k++) begin
            s_tvalid = 1; s_tlast = 0; s_tdata = DW'(k);
            cyc();
        end
        chk("full_cnt", o_count, DEPTH);
        chk("full_rdy", o_tready, 0);
        s_tdata = 16'h0099;
        cyc();
        drain("fill_drain_left");
        cyc(); cyc();
        chk("drain_vld", o_tvalid, 0);

        // Streaming: latency and steady occupancy
        s_tvalid = 1; m_tready = 1;
        for (int k = 0; k < 100; k++) begin
            s_tdata = DW'(k + 256);
            cyc();
            if (k == 0) chk("lat_n", o_tvalid, 0);
            if (k == 1) chk("lat_n1", o_tvalid, 0);
            if (k == 2) chk("lat_n2", o_tvalid, 1);
            if (k >= 2) chk("stream_cnt", o_count, 3);
        end
        drain("stream_left");

        // Random backpressure on both sides
        sent = 0;
        for (int k = 0; k < 8000 && (sent < 1000 || mq.size() > 0); k++) begin
            s_tvalid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            s_tdata  = DW'($urandom);
            s_tlast  = ($urandom_range(0, 7) == 0);
            m_tready = $urandom_range(0, 1);
            if (s_tvalid && o_tready) sent++;
            cyc();
        end
        chk("bp_sent", sent, 1000);
        chk("bp_left", mq.size(), 0);

        // Packet mode: output held until tlast is stored
        pm = 1; rst = 1; s_tvalid = 0; s_tlast = 0; m_tready = 0;
        cyc();
        rst = 0;
        cyc();
        for (int k = 0; k < 4; k++) begin
            s_tvalid = 1; s_tdata = DW'(16'h0500 + k);
            cyc();
        end
        s_tvalid = 0;
        cyc(); cyc(); cyc();
        chk("pkt_hold", o_tvalid, 0);
        s_tvalid = 1; s_tlast = 1; s_tdata = 16'h0504;
        cyc();
        s_tvalid = 0; s_tlast = 0;
        cyc(); cyc();
        chk("pkt_rel", o_tvalid, 1);
        chk("pkt_cnt1", o_pkt, 1);
        drain("pkt_left");
        cyc();
        chk("pkt_empty_vld", o_tvalid, 0);

        // Over-long packet: released only when the FIFO is full
        m_tready = 0; i = 0;
        for (int k = 0; k < 600 && i < 40; k++) begin
            s_tvalid = 1; s_tdata = DW'(16'h0600 + i); s_tlast = (i == 39);
            acc = o_tready;
            if (mq.size() == DEPTH) m_tready = 1;
            cyc();
            if (acc) i++;
            if (n_last() == 0) chk("big_vld", o_tvalid, mq.size() == DEPTH);
        end
        s_tlast = 0;
        chk("big_sent", i, 40);
        drain("big_left");

        // Reset in the middle of traffic
        m_tready = 0;
        for (int k = 0; k < 17; k++) begin
            s_tvalid = 1; s_tdata = DW'(16'h0700 + k); s_tlast = (k == 7 || k == 15);
            cyc();
        end
        s_tvalid = 0; s_tlast = 0;
        chk("pre_rst_cnt", o_count, 17);
        chk("pre_rst_pkt", o_pkt, 2);
        rst = 1;
        cyc();
        chk("mid_rst_cnt", o_count, 0);
        chk("mid_rst_pkt", o_pkt, 0);
        chk("mid_rst_vld", o_tvalid, 0);
        rst = 0;
        sent = 0;
        for (int k = 0; k < 4000 && sent < 300; k++) begin
            s_tvalid = ($urandom_range(0, 3) != 0);
            s_tdata  = DW'($urandom);
            s_tlast  = (sent == 299) || ($urandom_range(0, 5) == 0);
            m_tready = ($urandom_range(0, 9) < 7);
            if (s_tvalid && o_tready) sent++;
            cyc();
        end
        s_tlast = 0;
        chk("post_rst_sent", sent, 300);
        drain("post_rst_left");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
